// File: rtl/me_frame_server.sv
// me_frame_server: host-loaded current-block / reference-window pixel stores answering ME-core reads at 1-cycle latency.
// Build option ME_FRAME_SERVER_WRAP_EN: addresses wrap modulo store depth and addr_err is tied low.
module me_frame_server #(
   parameter int CUR_WORDS = 16,
   parameter int REF_WORDS = 128
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic        load_sel,
   input  logic [31:0] load_addr,
   input  logic [63:0] load_data,
   input  logic        load_done,
   input  logic        frame_clear,
   output logic        frame_ready,
   input  logic        cur_mem_en,
   input  logic [31:0] cur_mem_addr,
   input  logic        ref_mem_en,
   input  logic [31:0] ref_mem_addr,
   output logic [31:0] cur_in,
   output logic [63:0] ref_in,
   output logic        addr_err,
   output logic [1:0]  fsm_state
);
   localparam int CUR_AW = $clog2(CUR_WORDS);
   localparam int REF_AW = $clog2(REF_WORDS);

   localparam logic [1:0] ST_EMPTY   = 2'd0;
   localparam logic [1:0] ST_LOADING = 2'd1;
   localparam logic [1:0] ST_READY   = 2'd2;

   logic [1:0]  state, state_nxt;
   logic [31:0] cur_mem [CUR_WORDS];
   logic [63:0] ref_mem [REF_WORDS];

   logic              wr_acc, wr_ok, cur_rd_ok, ref_rd_ok, serving;
   logic [CUR_AW-1:0] wr_cur_idx, rd_cur_idx;
   logic [REF_AW-1:0] wr_ref_idx, rd_ref_idx;

   assign wr_cur_idx = load_addr[CUR_AW-1:0];
   assign wr_ref_idx = load_addr[REF_AW-1:0];
   assign rd_cur_idx = cur_mem_addr[CUR_AW-1:0];
   assign rd_ref_idx = ref_mem_addr[REF_AW-1:0];

`ifdef ME_FRAME_SERVER_WRAP_EN
   assign wr_ok     = 1'b1;
   assign cur_rd_ok = 1'b1;
   assign ref_rd_ok = 1'b1;
`else
   assign wr_ok     = load_sel ? (load_addr < 32'(REF_WORDS)) : (load_addr < 32'(CUR_WORDS));
   assign cur_rd_ok = cur_mem_addr < 32'(CUR_WORDS);
   assign ref_rd_ok = ref_mem_addr < 32'(REF_WORDS);
`endif

   // Write handshake: a beat transfers on every rising edge where load_valid && load_ready;
   // load_ready depends only on state (never on load_valid), and frame_clear drops the beat.
   assign load_ready  = (state != ST_READY);
   assign frame_ready = (state == ST_READY);
   assign fsm_state   = state;
   assign wr_acc      = load_valid && load_ready && !frame_clear;
   assign serving     = (state == ST_READY) && !frame_clear;

   always_comb begin
      state_nxt = state;
      if (frame_clear) begin
         state_nxt = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY:   if (wr_acc) state_nxt = ST_LOADING;
            ST_LOADING: if (load_done) state_nxt = ST_READY;
            ST_READY:   state_nxt = ST_READY;
            default:    state_nxt = ST_EMPTY;
         endcase
      end
   end

   // Stores are deliberately not reset; contents survive reset and frame_clear.
   always_ff @(posedge clk) begin
      if (wr_acc && wr_ok && !load_sel) cur_mem[wr_cur_idx] <= load_data[31:0];
      if (wr_acc && wr_ok && load_sel)  ref_mem[wr_ref_idx] <= load_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= ST_EMPTY;
         cur_in <= '0;
         ref_in <= '0;
      end else begin
         state <= state_nxt;
         if (cur_mem_en) cur_in <= (serving && cur_rd_ok) ? cur_mem[rd_cur_idx] : '0;
         if (ref_mem_en) ref_in <= (serving && ref_rd_ok) ? ref_mem[rd_ref_idx] : '0;
      end
   end

`ifdef ME_FRAME_SERVER_WRAP_EN
   assign addr_err = 1'b0;
`else
   logic err_set;
   assign err_set = (wr_acc && !wr_ok)
                  || (serving && cur_mem_en && !cur_rd_ok)
                  || (serving && ref_mem_en && !ref_rd_ok);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)             addr_err <= 1'b0;
      else if (frame_clear) addr_err <= 1'b0;
      else if (err_set)     addr_err <= 1'b1;
   end
`endif
endmodule

// File: tb/tb_me_frame_server.sv
// Self-checking bench for me_frame_server: directed sequence with random data checked against a store model.
module tb_me_frame_server;
   localparam int CW = 16;
   localparam int RW = 128;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_valid, load_ready, load_sel, load_done, frame_clear, frame_ready;
   logic [31:0] load_addr;
   logic [63:0] load_data;
   logic        cur_mem_en, ref_mem_en, addr_err;
   logic [31:0] cur_mem_addr, ref_mem_addr, cur_in;
   logic [63:0] ref_in;
   logic [1:0]  fsm_state;

   me_frame_server #(.CUR_WORDS(CW), .REF_WORDS(RW)) dut (
      .clk(clk), .rst(rst),
      .load_valid(load_valid), .load_ready(load_ready), .load_sel(load_sel),
      .load_addr(load_addr), .load_data(load_data), .load_done(load_done),
      .frame_clear(frame_clear), .frame_ready(frame_ready),
      .cur_mem_en(cur_mem_en), .cur_mem_addr(cur_mem_addr),
      .ref_mem_en(ref_mem_en), .ref_mem_addr(ref_mem_addr),
      .cur_in(cur_in), .ref_in(ref_in), .addr_err(addr_err), .fsm_state(fsm_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // reference model: frame phase flags, store images, sticky error, expected read outputs
   logic [31:0] m_cur [CW];
   logic [63:0] m_ref [RW];
   bit          m_ready, m_loading, m_err;
   logic [31:0] e_cur;
   logic [63:0] e_ref;
   logic [63:0] exp_q [$];

   function automatic bit in_cur(input logic [31:0] a);
`ifdef ME_FRAME_SERVER_WRAP_EN
      return 1'b1;
`else
      return a < CW;
`endif
   endfunction

   function automatic bit in_ref(input logic [31:0] a);
`ifdef ME_FRAME_SERVER_WRAP_EN
      return 1'b1;
`else
      return a < RW;
`endif
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_ready = 1'b0; m_loading = 1'b0; m_err = 1'b0;
   endtask

   task automatic idle();
      load_valid = 1'b0; load_sel = 1'b0; load_addr = '0; load_data = '0;
      load_done = 1'b0; frame_clear = 1'b0;
      cur_mem_en = 1'b0; cur_mem_addr = '0; ref_mem_en = 1'b0; ref_mem_addr = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ctrl(input string tag);
      chk({tag, ".load_ready"}, load_ready, !m_ready);
      chk({tag, ".frame_ready"}, frame_ready, m_ready);
      chk({tag, ".addr_err"}, addr_err, m_err);
   endtask

   // driver: one host write beat, optionally with load_done / frame_clear in the same cycle
   task automatic wr(input bit sel, input logic [31:0] addr, input logic [63:0] data,
                     input bit done, input bit clear);
      bit was_loading;
      load_valid = 1'b1; load_sel = sel; load_addr = addr; load_data = data;
      load_done = done; frame_clear = clear;
      if (clear) begin
         model_clear();
      end else if (!m_ready) begin
         was_loading = m_loading;
         if (sel ? in_ref(addr) : in_cur(addr)) begin
            if (sel) m_ref[addr % RW] = data;
            else     m_cur[addr % CW] = data[31:0];
         end else begin
            m_err = 1'b1;
         end
         if (was_loading && done) begin
            m_ready = 1'b1; m_loading = 1'b0;
         end else begin
            m_loading = 1'b1;
         end
      end
      step();
      idle();
      chk_ctrl("wr");
   endtask

   // driver: control pulses without a write
   task automatic ctrl(input bit done, input bit clear);
      load_done = done; frame_clear = clear;
      if (clear) model_clear();
      else if (m_loading && done) begin
         m_ready = 1'b1; m_loading = 1'b0;
      end
      step();
      idle();
      chk_ctrl("ctrl");
   endtask

   // driver: one read cycle on either/both ports, checked one edge later
   task automatic rd(input bit ce, input logic [31:0] ca, input bit re, input logic [31:0] ra);
      cur_mem_en = ce; cur_mem_addr = ca; ref_mem_en = re; ref_mem_addr = ra;
      if (ce) begin
         if (!m_ready)       e_cur = '0;
         else if (in_cur(ca)) e_cur = m_cur[ca % CW];
         else begin e_cur = '0; m_err = 1'b1; end
      end
      if (re) begin
         if (!m_ready)       e_ref = '0;
         else if (in_ref(ra)) e_ref = m_ref[ra % RW];
         else begin e_ref = '0; m_err = 1'b1; end
      end
      exp_q.push_back(64'(e_cur));
      exp_q.push_back(e_ref);
      step();
      idle();
      chk("rd.cur_in", cur_in, exp_q.pop_front());
      chk("rd.ref_in", ref_in, exp_q.pop_front());
      chk("rd.addr_err", addr_err, m_err);
   endtask

   initial begin
      logic [63:0] r;
      rst = 1'b0;
      idle();
      model_clear();
      e_cur = '0; e_ref = '0;
      #12;
      chk("rst.cur_in", cur_in, 0);
      chk("rst.ref_in", ref_in, 0);
      chk("rst.frame_ready", frame_ready, 0);
      chk("rst.addr_err", addr_err, 0);
      chk("rst.load_ready", load_ready, 1);
      @(negedge clk);
      rst = 1'b1;
      step();

      // load current block (upper data bits are junk), probing reads while LOADING
      for (int a = 0; a < CW; a++) begin
         wr(1'b0, 32'(a), {$urandom, 32'(a) * 32'h01010101}, 1'b0, 1'b0);
         if (a == 2) begin
            rd(1'b1, 32'd0, 1'b0, 32'd0);
            rd(1'b1, 32'd40, 1'b1, 32'd500);
         end
      end
      // load reference window; last beat carries load_done
      for (int a = 0; a < RW; a++)
         wr(1'b1, 32'(a), {$urandom, $urandom}, a == RW - 1, 1'b0);

      rd(1'b1, 32'd5, 1'b0, 32'd0);
      chk("cur5.literal", cur_in, 64'h05050505);

      repeat (20) rd(1'b1, 32'd3, 1'b1, 32'd100);
      repeat (40) rd(1'($urandom_range(0, 1)), 32'($urandom_range(0, CW - 1)),
                     1'($urandom_range(0, 1)), 32'($urandom_range(0, RW - 1)));

      // writes are refused while READY
      wr(1'b0, 32'd5, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 1'b0);
      rd(1'b1, 32'd5, 1'b0, 32'd0);

      // out-of-range reads, then sticky flag across a good read
      rd(1'b0, 32'd0, 1'b1, 32'd130);
      rd(1'b1, 32'd6, 1'b1, 32'd7);
      rd(1'b1, 32'h8000_0003, 1'b0, 32'd0);
      ctrl(1'b0, 1'b1);
      ctrl(1'b1, 1'b0);
      rd(1'b1, 32'd5, 1'b1, 32'd5);

      // clear collides with a write; write+done together; out-of-range write
      r = {$urandom, $urandom};
      wr(1'b0, 32'd7, r, 1'b0, 1'b0);
      wr(1'b0, 32'd7, {$urandom, $urandom}, 1'b0, 1'b1);
      wr(1'b0, 32'd20, {$urandom, $urandom}, 1'b0, 1'b0);
      wr(1'b1, 32'd3, {$urandom, $urandom}, 1'b1, 1'b0);
      rd(1'b1, 32'd7, 1'b1, 32'd3);
      chk("cur7.kept", cur_in, 64'(r[31:0]));
      rd(1'b1, 32'd4, 1'b0, 32'd0);

      // asynchronous reset between request and data
      rd(1'b1, 32'd5, 1'b1, 32'd100);
      cur_mem_en = 1'b1; cur_mem_addr = 32'd9; ref_mem_en = 1'b1; ref_mem_addr = 32'd50;
      #3;
      rst = 1'b0;
      #1;
      model_clear();
      e_cur = '0; e_ref = '0;
      chk("arst.cur_in", cur_in, 0);
      chk("arst.ref_in", ref_in, 0);
      chk_ctrl("arst");
      step();
      chk("arst.hold.cur_in", cur_in, 0);
      idle();
      rst = 1'b1;
      rd(1'b1, 32'd9, 1'b1, 32'd50);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
